// File: rtl/ex_wb_buffer_way0_pkg.sv
// Shared types for the execute-to-writeback result buffer, way 0.
// WB_TRACE_EN adds the instruction address to each buffered entry.
package ex_wb_buffer_way0_pkg;

    localparam logic [4:0] X0_ADDR = 5'd0;

    typedef struct packed {
        logic [4:0]  rdAddr;
        logic        rdWriteEnable;
        logic [63:0] rdWriteData;
        logic [1:0]  way0_pID;
`ifdef WB_TRACE_EN
        logic [31:0] instAddr;
`endif
    } wbEntry_t;

endpackage

// File: rtl/ex_wb_buffer_way0_fifo.sv
// Circular entry storage with read/write pointers and occupancy count.
// Flush and reset both empty the buffer; stored payload is left as-is.
module wb_fifo
    import ex_wb_buffer_way0_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  wbEntry_t      pushEntry,
    output wbEntry_t      storage [DEPTH],
    output logic [PW-1:0] rdPtr,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wrPtr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) storage[wrPtr] <= pushEntry;
    end

endmodule

// File: rtl/ex_wb_buffer_way0.sv
// Execute-to-writeback result buffer (way 0) with decode bypass.
// Optional WB_TRACE_EN: instAddr_o and a retire counter.
module ex_wb_buffer_way0
    import ex_wb_buffer_way0_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [4:0]  rdAddr_i,
    input  logic        rdWriteEnable_i,
    input  logic [63:0] rdWriteData_i,
    input  logic [31:0] instAddr_i,
    input  logic [1:0]  way0_pID_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [4:0]  rdAddr_o,
    output logic        rdWriteEnable_o,
    output logic [63:0] rdWriteData_o,
    output logic [1:0]  way0_pID_o,
`ifdef WB_TRACE_EN
    output logic [31:0] instAddr_o,
    output logic [63:0] retireCount_o,
`endif
    output logic        fwdValid_o,
    output logic [4:0]  fwdAddr_o,
    output logic [63:0] fwdData_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbEntry_t      storage [DEPTH];
    wbEntry_t      inEntry;
    wbEntry_t      head;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [PW-1:0] idx;
    logic          push;
    logic          pop;

    assign ready_o = (count != CW'(DEPTH));
    assign valid_o = (count != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_comb begin
        inEntry = '0;
        inEntry.rdAddr = rdAddr_i;
        inEntry.rdWriteEnable = rdWriteEnable_i
                              && (rdAddr_i != X0_ADDR);
        inEntry.rdWriteData = rdWriteData_i;
        inEntry.way0_pID = way0_pID_i;
`ifdef WB_TRACE_EN
        inEntry.instAddr = instAddr_i;
`endif
    end

`ifndef WB_TRACE_EN
    logic unusedInstAddr;
    assign unusedInstAddr = ^instAddr_i;
`endif

    wb_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .push      (push),
        .pop       (pop),
        .pushEntry (inEntry),
        .storage   (storage),
        .rdPtr     (rdPtr),
        .count     (count)
    );

    // Head fields read as zero whenever nothing is buffered.
    always_comb begin
        head = '0;
        if (valid_o) head = storage[rdPtr];
    end

    assign rdAddr_o        = head.rdAddr;
    assign rdWriteEnable_o = head.rdWriteEnable && valid_o;
    assign rdWriteData_o   = head.rdWriteData;
    assign way0_pID_o      = head.way0_pID;

    // Walk oldest to youngest so the last writing entry wins.
    always_comb begin
        fwdValid_o = 1'b0;
        fwdAddr_o  = '0;
        fwdData_o  = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rdPtr + PW'(k);
            if ((CW'(k) < count) && storage[idx].rdWriteEnable) begin
                fwdValid_o = 1'b1;
                fwdAddr_o  = storage[idx].rdAddr;
                fwdData_o  = storage[idx].rdWriteData;
            end
        end
    end

`ifdef WB_TRACE_EN
    assign instAddr_o = head.instAddr;

    // Flush does not clear the count: retires still happened.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retireCount_o <= '0;
        end else if (pop) begin
            retireCount_o <= retireCount_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_wb_buffer_way0.sv
// Self-checking bench for ex_wb_buffer_way0 against a queue model.
module tb_ex_wb_buffer_way0;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [4:0]  rdAddr_i = '0;
    logic        rdWriteEnable_i = 1'b0;
    logic [63:0] rdWriteData_i = '0;
    logic [31:0] instAddr_i = '0;
    logic [1:0]  way0_pID_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [4:0]  rdAddr_o;
    logic        rdWriteEnable_o;
    logic [63:0] rdWriteData_o;
    logic [1:0]  way0_pID_o;
    logic        fwdValid_o;
    logic [4:0]  fwdAddr_o;
    logic [63:0] fwdData_o;
`ifdef WB_TRACE_EN
    logic [31:0] instAddr_o;
    logic [63:0] retireCount_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [63:0] data;
        logic [1:0]  pid;
        logic [31:0] inst;
    } mEntry_t;

    mEntry_t q[$];
    longint unsigned mRetires = 0;

    ex_wb_buffer_way0 #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .rdAddr_i        (rdAddr_i),
        .rdWriteEnable_i (rdWriteEnable_i),
        .rdWriteData_i   (rdWriteData_i),
        .instAddr_i      (instAddr_i),
        .way0_pID_i      (way0_pID_i),
        .flush_i         (flush_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .rdAddr_o        (rdAddr_o),
        .rdWriteEnable_o (rdWriteEnable_o),
        .rdWriteData_o   (rdWriteData_o),
        .way0_pID_o      (way0_pID_o),
`ifdef WB_TRACE_EN
        .instAddr_o      (instAddr_o),
        .retireCount_o   (retireCount_o),
`endif
        .fwdValid_o      (fwdValid_o),
        .fwdAddr_o       (fwdAddr_o),
        .fwdData_o       (fwdData_o)
    );

    always #5 clk = ~clk;

    // One clock: model updates from the inputs held across the edge.
    task automatic cycle();
        bit acc;
        bit ret;
        mEntry_t e;
        @(posedge clk);
        acc = valid_i && (q.size() != DEPTH);
        ret = ready_i && (q.size() != 0);
        if (!rst_n) begin
            q.delete();
            mRetires = 0;
        end else begin
            if (ret) mRetires++;
            if (flush_i) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) begin
                    e.rd = rdAddr_i;
                    e.we = rdWriteEnable_i && (rdAddr_i != 0);
                    e.data = rdWriteData_i;
                    e.pid = way0_pID_i;
                    e.inst = instAddr_i;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd,
                         input logic we, input logic [63:0] d);
        valid_i = v;
        rdAddr_i = rd;
        rdWriteEnable_i = we;
        rdWriteData_i = d;
        way0_pID_i = rd[1:0];
        instAddr_i = {27'h0, rd} << 2;
    endtask

    function automatic logic [143:0] expOut();
        logic v, r, we, fv;
        logic [4:0] a, fa;
        logic [63:0] d, fd;
        logic [1:0] p;
        v = q.size() != 0;
        r = q.size() != DEPTH;
        a = '0; we = 0; d = '0; p = '0;
        fv = 0; fa = '0; fd = '0;
        if (v) begin
            a = q[0].rd; we = q[0].we;
            d = q[0].data; p = q[0].pid;
        end
        foreach (q[i]) begin
            if (q[i].we) begin
                fv = 1; fa = q[i].rd; fd = q[i].data;
            end
        end
        return {v, r, a, we, d, p, fv, fa, fd};
    endfunction

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 0, 0);
        cycle();
        cycle();
        checks++;
        if (valid_o !== 1'b0 || fwdValid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got v=%b f=%b want 0 0",
                     valid_o, fwdValid_o);
        end
        checks++;
        if (rdWriteData_o !== 64'h0 || rdAddr_o !== 5'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0",
                     rdWriteData_o, rdAddr_o);
        end
        rst_n = 1;
        cycle();
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", ready_o);
        end
    endtask

    task automatic test_single();
        ready_i = 1;
        drive(1, 5, 1, 64'h1234);
        cycle();
        drive(0, 0, 0, 0);
        checks++;
        if ({valid_o, rdAddr_o, rdWriteData_o, rdWriteEnable_o}
            !== {1'b1, 5'd5, 64'h1234, 1'b1}) begin
            errors++;
            $display("FAIL single_head got v=%b a=%0d d=%h we=%b want 1 5 1234 1",
                     valid_o, rdAddr_o, rdWriteData_o, rdWriteEnable_o);
        end
        cycle();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_empty got %b want 0", valid_o);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 0;
        drive(1, 1, 1, 64'd1);
        cycle();
        drive(1, 2, 1, 64'd2);
        cycle();
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got ready=%b want 0", ready_o);
        end
        drive(1, 3, 1, 64'd3);
        cycle();
        checks++;
        if (ready_o !== 1'b0 || rdWriteData_o !== 64'd1) begin
            errors++;
            $display("FAIL bp_hold got ready=%b d=%0d want 0 1",
                     ready_o, rdWriteData_o);
        end
        ready_i = 1;
        cycle();
        checks++;
        if (rdWriteData_o !== 64'd2 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got d=%0d r=%b want 2 1",
                     rdWriteData_o, ready_o);
        end
        cycle();
        drive(0, 0, 0, 0);
        checks++;
        if (rdWriteData_o !== 64'd3 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_third got d=%0d v=%b want 3 1",
                     rdWriteData_o, valid_o);
        end
        cycle();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got %b want 0", valid_o);
        end
    endtask

    task automatic test_x0();
        ready_i = 0;
        drive(1, 0, 1, 64'h55);
        cycle();
        drive(0, 0, 0, 0);
        checks++;
        if ({valid_o, rdWriteEnable_o, fwdValid_o} !== 3'b100) begin
            errors++;
            $display("FAIL x0_we got v=%b we=%b fv=%b want 1 0 0",
                     valid_o, rdWriteEnable_o, fwdValid_o);
        end
        ready_i = 1;
        cycle();
    endtask

    task automatic test_forward();
        ready_i = 0;
        drive(1, 3, 1, 64'hA);
        cycle();
        drive(1, 3, 1, 64'hB);
        cycle();
        drive(0, 0, 0, 0);
        checks++;
        if ({fwdValid_o, fwdAddr_o, fwdData_o}
            !== {1'b1, 5'd3, 64'hB}) begin
            errors++;
            $display("FAIL fwd_young got fv=%b a=%0d d=%h want 1 3 b",
                     fwdValid_o, fwdAddr_o, fwdData_o);
        end
        checks++;
        if (rdWriteData_o !== 64'hA) begin
            errors++;
            $display("FAIL fwd_head got %h want a", rdWriteData_o);
        end
    endtask

    task automatic test_flush();
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre got ready=%b want 0", ready_o);
        end
        drive(1, 7, 1, 64'hC);
        flush_i = 1;
        cycle();
        flush_i = 0;
        drive(0, 0, 0, 0);
        checks++;
        if ({valid_o, ready_o, fwdValid_o} !== 3'b010) begin
            errors++;
            $display("FAIL flush_empty got v=%b r=%b fv=%b want 0 1 0",
                     valid_o, ready_o, fwdValid_o);
        end
        cycle();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got v=%b want 0", valid_o);
        end
    endtask

`ifdef WB_TRACE_EN
    task automatic test_trace();
        rst_n = 0;
        cycle();
        rst_n = 1;
        ready_i = 1;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 1, 64'(i));
            cycle();
        end
        drive(0, 0, 0, 0);
        cycle();
        checks++;
        if (retireCount_o !== 64'd4) begin
            errors++;
            $display("FAIL trace_four got %0d want 4", retireCount_o);
        end
        flush_i = 1;
        cycle();
        flush_i = 0;
        drive(1, 9, 1, 64'h9);
        cycle();
        drive(0, 0, 0, 0);
        cycle();
        checks++;
        if (retireCount_o !== 64'd5) begin
            errors++;
            $display("FAIL trace_five got %0d want 5", retireCount_o);
        end
        rst_n = 0;
        cycle();
        rst_n = 1;
        checks++;
        if (retireCount_o !== 64'd0) begin
            errors++;
            $display("FAIL trace_reset got %0d want 0", retireCount_o);
        end
    endtask
`endif

    task automatic test_random();
        logic [143:0] got;
        logic [143:0] want;
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            flush_i = ($urandom_range(0, 24) == 0);
            ready_i = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                              : 5'($urandom_range(0, 3)),
                  1'($urandom),
                  {$urandom, $urandom});
            instAddr_i = $urandom;
            way0_pID_i = 2'($urandom);
            cycle();
            got = {valid_o, ready_o, rdAddr_o, rdWriteEnable_o,
                   rdWriteData_o, way0_pID_o, fwdValid_o,
                   fwdAddr_o, fwdData_o};
            want = expOut();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rand_out n=%0d got %h want %h",
                         n, got, want);
            end
`ifdef WB_TRACE_EN
            checks++;
            if (retireCount_o !== 64'(mRetires)) begin
                errors++;
                $display("FAIL rand_count n=%0d got %0d want %0d",
                         n, retireCount_o, mRetires);
            end
            checks++;
            if (instAddr_o !== ((q.size() != 0) ? q[0].inst : 32'h0)) begin
                errors++;
                $display("FAIL rand_inst n=%0d got %h", n, instAddr_o);
            end
`endif
        end
        rst_n = 1;
        flush_i = 0;
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_x0();
        test_forward();
        test_flush();
`ifdef WB_TRACE_EN
        test_trace();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
